// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: instruction, data and memory-side handshake signals of mem_port_arbiter.
interface mem_port_arbiter_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [3:0]  inst_mask;
    logic        inst_valid;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_we_re;
    logic [31:0] data_addr;
    logic [3:0]  data_mask;
    logic [31:0] data_wdata;
    logic        data_valid;
    logic [31:0] data_rdata;
    logic        mem_request;
    logic        mem_we_re;
    logic [31:0] mem_addr;
    logic [3:0]  mem_mask;
    logic [31:0] mem_wdata;
    logic        mem_valid;
    logic [31:0] mem_rdata;
    modport master (
        input  inst_req, inst_addr, inst_mask,
        output inst_valid, inst_rdata,
        input  data_req, data_we_re, data_addr, data_mask, data_wdata,
        output data_valid, data_rdata,
        output mem_request, mem_we_re, mem_addr, mem_mask, mem_wdata,
        input  mem_valid, mem_rdata
    );
    modport slave (
        output inst_req, inst_addr, inst_mask,
        input  inst_valid, inst_rdata,
        output data_req, data_we_re, data_addr, data_mask, data_wdata,
        input  data_valid, data_rdata,
        input  mem_request, mem_we_re, mem_addr, mem_mask, mem_wdata,
        output mem_valid, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: instruction/data requesters sharing one memory port; define MEM_ARB_FAIRNESS_EN for fetch starvation protection.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic clk,
    input logic rst,
    mem_port_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, INST_BUSY, DATA_BUSY} state_t;
    state_t state;
    logic arb_open;
    logic inst_win;
    logic data_win;
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_limit_check
        $error("STARVE_LIMIT must be in 1..15");
    end
`ifdef MEM_ARB_FAIRNESS_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    logic [3:0] starve_cnt;
    // Grant only in a clean IDLE cycle; a waiting fetch wins once data has overtaken it LIMIT times.
    always_comb begin
        arb_open = state == IDLE && !bus.inst_valid && !bus.data_valid;
        inst_win = arb_open && bus.inst_req && (!bus.data_req || starve_cnt == LIMIT);
        data_win = arb_open && bus.data_req && !inst_win;
    end
    // Count data grants that overtake a pending fetch; any fetch grant clears the count.
    always_ff @(posedge clk) begin
        if (rst || inst_win) starve_cnt <= '0;
        else if (data_win && bus.inst_req && starve_cnt != 4'hF) starve_cnt <= starve_cnt + 4'd1;
    end
`else
    // Grant only in a clean IDLE cycle, strictly data first; the completion cycle is a turnaround slot.
    always_comb begin
        arb_open = state == IDLE && !bus.inst_valid && !bus.data_valid;
        inst_win = arb_open && bus.inst_req && !bus.data_req;
        data_win = arb_open && bus.data_req;
    end
`endif
    // Main FSM: latch the winner onto the memory port, hold it until mem_valid, then pulse the owner's valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            bus.mem_request <= 1'b0;
            bus.mem_we_re <= 1'b0;
            bus.mem_addr <= '0;
            bus.mem_mask <= '0;
            bus.mem_wdata <= '0;
            bus.inst_valid <= 1'b0;
            bus.data_valid <= 1'b0;
            bus.inst_rdata <= '0;
            bus.data_rdata <= '0;
        end else begin
            bus.inst_valid <= 1'b0;
            bus.data_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (inst_win) begin
                        state <= INST_BUSY;
                        bus.mem_request <= 1'b1;
                        bus.mem_we_re <= 1'b0;
                        bus.mem_addr <= bus.inst_addr;
                        bus.mem_mask <= bus.inst_mask;
                        bus.mem_wdata <= '0;
                    end else if (data_win) begin
                        state <= DATA_BUSY;
                        bus.mem_request <= 1'b1;
                        bus.mem_we_re <= bus.data_we_re;
                        bus.mem_addr <= bus.data_addr;
                        bus.mem_mask <= bus.data_mask;
                        bus.mem_wdata <= bus.data_wdata;
                    end
                end
                INST_BUSY: begin
                    if (bus.mem_valid) begin
                        state <= IDLE;
                        bus.mem_request <= 1'b0;
                        bus.inst_valid <= 1'b1;
                        bus.inst_rdata <= bus.mem_rdata;
                    end
                end
                DATA_BUSY: begin
                    if (bus.mem_valid) begin
                        state <= IDLE;
                        bus.mem_request <= 1'b0;
                        bus.data_valid <= 1'b1;
                        bus.data_rdata <= bus.mem_we_re ? '0 : bus.mem_rdata;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
